// File: rtl/nxn_parallel_crossbar_if.sv
// ---------------------------------------------------------------------------
// nxn_parallel_crossbar_if
//
// Purpose
//   Bundles the flit-side and link-side handshake signals of the NxN parallel
//   crossbar. Flits are packed per port: port k occupies
//   [k*DATA_W +: DATA_W] of the data vectors and [k*SEL_W +: SEL_W] of dst_i.
//
// Parameters
//   DATA_W   flit width in bits
//   PORT_N   number of input ports and of output ports
//   SEL_W    destination select width, derived from PORT_N
//
// Signals (direction as seen by the crossbar)
//   data_i   in   PORT_N*DATA_W  input flits
//   valid_i  in   PORT_N         input flit k valid
//   dst_i    in   PORT_N*SEL_W   destination output of input k
//   ready_o  out  PORT_N         input k flit accepted this cycle
//   data_o   out  PORT_N*DATA_W  output flits (registered)
//   valid_o  out  PORT_N         output j holds a flit (registered)
//   ready_i  in   PORT_N         downstream of output j accepts
//   drop_o   out  1              pulse: flit(s) with out-of-range dst discarded
//
// Modports
//   master   upstream buffers + downstream link drivers (drives the inputs)
//   slave    the crossbar itself
// ---------------------------------------------------------------------------
interface nxn_parallel_crossbar_if #(
    parameter int DATA_W = 8,
    parameter int PORT_N = 5
);
    localparam int SEL_W = $clog2(PORT_N);

    logic [PORT_N*DATA_W-1:0] data_i;
    logic [PORT_N-1:0]        valid_i;
    logic [PORT_N*SEL_W-1:0]  dst_i;
    logic [PORT_N-1:0]        ready_o;
    logic [PORT_N*DATA_W-1:0] data_o;
    logic [PORT_N-1:0]        valid_o;
    logic [PORT_N-1:0]        ready_i;
    logic                     drop_o;

    modport master (
        output data_i,
        output valid_i,
        output dst_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  valid_o,
        input  drop_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        input  dst_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output valid_o,
        output drop_o
    );
endinterface

// File: rtl/nxn_parallel_crossbar.sv
// ---------------------------------------------------------------------------
// nxn_parallel_crossbar
//
// Purpose
//   Registered NxN switch crossbar for the NoC router datapath. Every input
//   carries its own destination select, so up to PORT_N disjoint
//   input->output transfers complete in the same cycle. Each output owns an
//   independent arbiter and a single output register with a valid/ready
//   handshake towards the link driver.
//
// Configuration macro
//   NXN_XBAR_RR_ARB_EN  defined:   round-robin arbiter per output, pointer
//                                  ptr[j] restarts the search after the last
//                                  granted input.
//                       undefined: fixed priority, lowest input index wins;
//                                  no pointer state is built.
//
// Parameters
//   DATA_W   flit width in bits
//   PORT_N   number of input and output ports
//
// Ports
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (released synchronously upstream)
//   bus      nxn_parallel_crossbar_if.slave: data_i/valid_i/dst_i/ready_o on
//            the input side, data_o/valid_o/ready_i on the output side, and
//            the drop_o pulse for flits addressed to a non-existent output.
// ---------------------------------------------------------------------------
module nxn_parallel_crossbar #(
    parameter int DATA_W = 8,
    parameter int PORT_N = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    nxn_parallel_crossbar_if.slave bus
);
    localparam int SEL_W = $clog2(PORT_N);

    // Unpacked views of the input side
    logic [DATA_W-1:0] flit_p0 [PORT_N];
    logic [SEL_W-1:0]  dst_p0  [PORT_N];
    logic [PORT_N-1:0] bad_p0;

    // Request / grant matrices, indexed [output j][input k]
    logic [PORT_N-1:0] req_p0 [PORT_N];
    logic [PORT_N-1:0] gnt_p0 [PORT_N];
    // Completed grants transposed to [input k][output j] for ready_o
    logic [PORT_N-1:0] win_p0 [PORT_N];
    logic [PORT_N-1:0] ld_en_p0;
    logic [DATA_W-1:0] sel_p0 [PORT_N];

    // Output registers
    logic [DATA_W-1:0] data_p1 [PORT_N];
    logic [PORT_N-1:0] vld_p1;
    logic              drop_p1;

`ifdef NXN_XBAR_RR_ARB_EN
    logic [SEL_W-1:0] ptr_p1  [PORT_N];
    logic [SEL_W-1:0] gidx_p0 [PORT_N];

    // Round-robin pick: rotate the request vector so ptr sits at bit 0,
    // isolate the lowest set bit, then rotate the one-hot result back.
    function automatic logic [PORT_N-1:0] rr_pick(input logic [PORT_N-1:0] req,
                                                  input logic [SEL_W-1:0]  ptr);
        logic [PORT_N-1:0] rot;
        logic [PORT_N-1:0] lsb;
        rot = PORT_N'({req, req} >> ptr);
        lsb = rot & (~rot + 1'b1);
        return PORT_N'(({lsb, lsb} << ptr) >> PORT_N);
    endfunction

    function automatic logic [SEL_W-1:0] onehot_idx(input logic [PORT_N-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < PORT_N; k++) begin
            if (oh[k]) begin
                idx = SEL_W'(k);
            end
        end
        return idx;
    endfunction
`else
    // Fixed priority: lowest requesting index wins.
    function automatic logic [PORT_N-1:0] fp_pick(input logic [PORT_N-1:0] req);
        return req & (~req + 1'b1);
    endfunction
`endif

    // ---- stage p0: request decode, arbitration, input acceptance ----
    for (genvar k = 0; k < PORT_N; k++) begin : g_in
        assign flit_p0[k] = bus.data_i[k*DATA_W +: DATA_W];
        assign dst_p0[k]  = bus.dst_i[k*SEL_W +: SEL_W];
        // Extra leading zero so PORT_N itself is representable when it is a
        // power of two (the compare is then constant false).
        assign bad_p0[k]  = bus.valid_i[k] && ({1'b0, dst_p0[k]} >= (SEL_W+1)'(PORT_N));
    end

    for (genvar j = 0; j < PORT_N; j++) begin : g_req
        for (genvar k = 0; k < PORT_N; k++) begin : g_req_k
            assign req_p0[j][k] = bus.valid_i[k] && (dst_p0[k] == SEL_W'(j));
        end
    end

    // An output may load when it is empty or its current flit leaves now.
    assign ld_en_p0 = ~vld_p1 | bus.ready_i;

    for (genvar j = 0; j < PORT_N; j++) begin : g_arb
`ifdef NXN_XBAR_RR_ARB_EN
        assign gnt_p0[j] = rr_pick(req_p0[j], ptr_p1[j]);
`else
        assign gnt_p0[j] = fp_pick(req_p0[j]);
`endif
    end

    for (genvar k = 0; k < PORT_N; k++) begin : g_win
        for (genvar j = 0; j < PORT_N; j++) begin : g_win_j
            assign win_p0[k][j] = gnt_p0[j][k] & ld_en_p0[j];
        end
        // Out-of-range destinations are always swallowed so they never block
        // the input. Nothing is accepted while reset is asserted.
        assign bus.ready_o[k] = rst_ni & (bad_p0[k] | (|win_p0[k]));
    end

    // One-hot data mux per output
    always_comb begin
        for (int j = 0; j < PORT_N; j++) begin
            sel_p0[j] = '0;
            for (int k = 0; k < PORT_N; k++) begin
                if (gnt_p0[j][k]) begin
                    sel_p0[j] = flit_p0[k];
                end
            end
        end
    end

`ifdef NXN_XBAR_RR_ARB_EN
    always_comb begin
        for (int j = 0; j < PORT_N; j++) begin
            gidx_p0[j] = onehot_idx(gnt_p0[j]);
        end
    end
`endif

    // ---- stage p1: output registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < PORT_N; j++) begin
                data_p1[j] <= '0;
            end
            vld_p1  <= '0;
            drop_p1 <= 1'b0;
        end else begin
            for (int j = 0; j < PORT_N; j++) begin
                if (ld_en_p0[j]) begin
                    // No requester: the register empties but keeps its data.
                    vld_p1[j] <= |gnt_p0[j];
                    if (|gnt_p0[j]) begin
                        data_p1[j] <= sel_p0[j];
                    end
                end
            end
            drop_p1 <= |bad_p0;
        end
    end

`ifdef NXN_XBAR_RR_ARB_EN
    // Pointer moves only on a grant that actually completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < PORT_N; j++) begin
                ptr_p1[j] <= '0;
            end
        end else begin
            for (int j = 0; j < PORT_N; j++) begin
                if (ld_en_p0[j] && (|gnt_p0[j])) begin
                    ptr_p1[j] <= (gidx_p0[j] == SEL_W'(PORT_N-1)) ? '0 : gidx_p0[j] + 1'b1;
                end
            end
        end
    end
`endif

    for (genvar j = 0; j < PORT_N; j++) begin : g_out
        assign bus.data_o[j*DATA_W +: DATA_W] = data_p1[j];
    end
    assign bus.valid_o = vld_p1;
    assign bus.drop_o  = drop_p1;

endmodule

// File: tb/tb_nxn_parallel_crossbar.sv
// ---------------------------------------------------------------------------
// tb_nxn_parallel_crossbar
//
// Directed and constrained-random stimulus for nxn_parallel_crossbar
// (PORT_N=5, DATA_W=8). The stimulus process pushes every flit it expects to
// see on output j into exp_q[j]; a separate monitor pops and compares each
// time an output flit is consumed (valid_o && ready_i).
// ---------------------------------------------------------------------------
module tb_nxn_parallel_crossbar;
    localparam int DATA_W = 8;
    localparam int PORT_N = 5;
    localparam int SEL_W  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    nxn_parallel_crossbar_if #(.DATA_W(DATA_W), .PORT_N(PORT_N)) bus ();

    nxn_parallel_crossbar #(.DATA_W(DATA_W), .PORT_N(PORT_N)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q [PORT_N][$];
    logic [DATA_W-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input int dst, input logic [DATA_W-1:0] f);
        bus.valid_i[k] = 1'b1;
        bus.dst_i[k*SEL_W +: SEL_W] = SEL_W'(dst);
        bus.data_i[k*DATA_W +: DATA_W] = f;
    endtask

    function automatic logic [DATA_W-1:0] out_flit(input int j);
        return bus.data_o[j*DATA_W +: DATA_W];
    endfunction

    // Scoreboard monitor: every consumed output flit must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < PORT_N; j++) begin
                if (bus.valid_o[j] && bus.ready_i[j]) begin
                    if (exp_q[j].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL out%0d_unexpected: got flit 0x%0h, required none", j, out_flit(j));
                    end else begin
                        mon_exp = exp_q[j].pop_front();
                        check($sformatf("out%0d_data", j), 32'(out_flit(j)), 32'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    // Contention grant order on output 1 for inputs 1,2,4
`ifdef NXN_XBAR_RR_ARB_EN
    int win_tab [6] = '{1, 2, 4, 1, 2, 4};
`else
    int win_tab [6] = '{1, 1, 1, 1, 1, 1};
`endif

    logic [4:0]        seq [PORT_N];
    int                wait_cnt [PORT_N];
    logic [PORT_N-1:0] acc;
    logic              prev_bad;
    int                d;
    int                per_out;

    initial begin
        bus.data_i  = '0;
        bus.valid_i = '0;
        bus.dst_i   = '0;
        bus.ready_i = '1;

        // ---- 1: reset state and release priority ----
        repeat (2) step();
        check("rst_valid_o", 32'(bus.valid_o), 32'h0);
        check("rst_data_o", 32'(bus.data_o), 32'h0);
        check("rst_drop_o", 32'(bus.drop_o), 32'h0);
        put(0, 0, 8'h11);
        #1;
        check("rst_ready_o", 32'(bus.ready_o), 32'h0);
        bus.valid_i = '0;
        rst_n = 1'b1;
        step();

        put(0, 0, 8'h11);
        put(2, 0, 8'h22);
        bus.ready_i = 5'b11110;
        #1;
        check("rel_ready_prio", 32'(bus.ready_o), 32'b00001);
        exp_q[0].push_back(8'h11);
        step();
        bus.valid_i[0] = 1'b0;
        #1;
        check("held_ready_o", 32'(bus.ready_o), 32'h0);
        check("held_valid_o", 32'(bus.valid_o), 32'b00001);
        check("held_data_o0", 32'(out_flit(0)), 32'h11);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_o", 32'(bus.valid_o), 32'h0);
        check("async_rst_data_o", 32'(bus.data_o), 32'h0);
        check("async_rst_ready_o", 32'(bus.ready_o), 32'h0);
        exp_q[0].delete();
        bus.valid_i = '0;
        bus.ready_i = '1;
        step();
        rst_n = 1'b1;
        step();

        put(0, 0, 8'h10);
        put(2, 0, 8'h22);
        #1;
        check("post_rst_prio", 32'(bus.ready_o), 32'b00001);
        exp_q[0].push_back(8'h10);
        step();
        bus.valid_i[0] = 1'b0;
        #1;
        check("post_rst_second", 32'(bus.ready_o), 32'b00100);
        exp_q[0].push_back(8'h22);
        check("post_rst_valid_o", 32'(bus.valid_o), 32'b00001);
        check("post_rst_data_o0", 32'(out_flit(0)), 32'h10);
        step();
        bus.valid_i = '0;
        check("post_rst_data_o0b", 32'(out_flit(0)), 32'h22);
        step();
        check("drain_valid_o", 32'(bus.valid_o), 32'h0);
        check("drain_data_hold", 32'(out_flit(0)), 32'h22);

        // ---- 2: parallel disjoint transfers ----
        put(0, 3, 8'hA0);
        put(1, 0, 8'hB1);
        put(4, 2, 8'hC4);
        #1;
        check("par_ready_o", 32'(bus.ready_o), 32'b10011);
        exp_q[3].push_back(8'hA0);
        exp_q[0].push_back(8'hB1);
        exp_q[2].push_back(8'hC4);
        step();
        bus.valid_i = '0;
        check("par_valid_o", 32'(bus.valid_o), 32'b01101);
        check("par_data_o3", 32'(out_flit(3)), 32'hA0);
        check("par_data_o0", 32'(out_flit(0)), 32'hB1);
        check("par_data_o2", 32'(out_flit(2)), 32'hC4);
        step();
        check("par_drain", 32'(bus.valid_o), 32'h0);

        // ---- 3: contention on output 1 ----
        put(1, 1, 8'h31);
        put(2, 1, 8'h32);
        put(4, 1, 8'h34);
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("cont_grant%0d", c), 32'(bus.ready_o), 32'(5'b1 << win_tab[c]));
            exp_q[1].push_back(8'h30 + 8'(win_tab[c]));
            step();
        end
        bus.valid_i = '0;
        step();
        step();

        // ---- 4: backpressure on output 2 ----
        put(3, 2, 8'h55);
        #1;
        check("bp_first_ready", 32'(bus.ready_o), 32'b01000);
        exp_q[2].push_back(8'h55);
        step();
        bus.valid_i = '0;
        bus.ready_i[2] = 1'b0;
        put(0, 2, 8'h66);
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_ready_o%0d", c), 32'(bus.ready_o), 32'h0);
            check($sformatf("bp_valid2_%0d", c), 32'(bus.valid_o[2]), 32'h1);
            check($sformatf("bp_data2_%0d", c), 32'(out_flit(2)), 32'h55);
            step();
        end
        bus.ready_i[2] = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.ready_o), 32'b00001);
        exp_q[2].push_back(8'h66);
        step();
        bus.valid_i = '0;
        check("bp_no_bubble_valid", 32'(bus.valid_o[2]), 32'h1);
        check("bp_no_bubble_data", 32'(out_flit(2)), 32'h66);
        step();

        // ---- 5: bad destination ----
        put(3, 6, 8'h77);
        #1;
        check("bad_ready_o", 32'(bus.ready_o), 32'b01000);
        check("bad_drop_before", 32'(bus.drop_o), 32'h0);
        step();
        bus.valid_i = '0;
        check("bad_drop_pulse", 32'(bus.drop_o), 32'h1);
        check("bad_valid_o", 32'(bus.valid_o), 32'h0);
        step();
        check("bad_drop_end", 32'(bus.drop_o), 32'h0);

        // ---- 6: random traffic under the hold-until-accepted contract ----
        prev_bad = 1'b0;
        for (int k = 0; k < PORT_N; k++) begin
            seq[k] = '0;
            wait_cnt[k] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < PORT_N; k++) begin
                if (!bus.valid_i[k] && ($urandom_range(0, 3) != 0)) begin
                    put(k, int'($urandom_range(0, 5)), {3'(k), seq[k]});
                    seq[k] = seq[k] + 5'd1;
                end
            end
            bus.ready_i = PORT_N'($urandom) | PORT_N'($urandom);
            #1;
            check("rand_drop", 32'(bus.drop_o), 32'(prev_bad));
            check("rand_ready_only_valid", 32'(bus.ready_o & ~bus.valid_i), 32'h0);
            acc = bus.valid_i & bus.ready_o;
            prev_bad = 1'b0;
            for (int j = 0; j < PORT_N; j++) begin
                per_out = 0;
                for (int k = 0; k < PORT_N; k++) begin
                    if (acc[k] && int'(bus.dst_i[k*SEL_W +: SEL_W]) == j) per_out++;
                end
                if (per_out != 0) check($sformatf("rand_one_per_out%0d", j), 32'(per_out), 32'h1);
            end
            for (int k = 0; k < PORT_N; k++) begin
                d = int'(bus.dst_i[k*SEL_W +: SEL_W]);
                if (acc[k]) begin
                    if (d >= PORT_N) prev_bad = 1'b1;
                    else exp_q[d].push_back(bus.data_i[k*DATA_W +: DATA_W]);
`ifdef NXN_XBAR_RR_ARB_EN
                    if (d < PORT_N) check($sformatf("rand_rr_wait_in%0d", k), 32'(wait_cnt[k] <= PORT_N-1), 32'h1);
`endif
                    wait_cnt[k] = 0;
                end else if (bus.valid_i[k]) begin
                    for (int k2 = 0; k2 < PORT_N; k2++) begin
                        if (acc[k2] && int'(bus.dst_i[k2*SEL_W +: SEL_W]) == d) wait_cnt[k]++;
                    end
                end
            end
            step();
            bus.valid_i = bus.valid_i & ~acc;
        end
        bus.valid_i = '0;
        bus.ready_i = '1;
        #1;
        check("rand_last_drop", 32'(bus.drop_o), 32'(prev_bad));
        repeat (3) step();
        for (int j = 0; j < PORT_N; j++) begin
            check($sformatf("queue_empty_out%0d", j), 32'(exp_q[j].size()), 32'h0);
        end
        check("final_valid_o", 32'(bus.valid_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
